stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Two-button sequencer for the 32-bit stopwatch counter block.
- Turns debounced, synchronized button levels into the one-cycle `start`, `stop` and `reset` command pulses the counter expects.
- Captures lap times, stops the counter automatically at a terminal count, and selects which value goes to the display path.
- Sits between the button conditioning logic and the stopwatch/display datapath.

Parameters:
- MAX_COUNT, 32'hFFFF_FF00: terminal count. Auto-stop fires when `count_in >= MAX_COUNT`.
- WIDTH, 32: count width. Must match the stopwatch counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_ss  in  1  start/stop button level; debounced and synchronized upstream.
- btn_lr  in  1  lap/reset button level; debounced and synchronized upstream.
- count_in  in  WIDTH  live count from the stopwatch.
- sw_start  out  1  one-cycle start pulse to the stopwatch.
- sw_stop  out  1  one-cycle stop pulse to the stopwatch.
- sw_reset  out  1  one-cycle reset pulse to the stopwatch.
- disp_count  out  WIDTH  value for the display path.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP.
- maxed  out  1  high in MAXED.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All pulses, `running`, `lap_active` and `maxed` = 0.
  - `disp_count` = 0; lap register = 0.
  - Both edge-detector history flops = 1, so a button held through reset produces no edge.
- Edge detection: `ss_e = btn_ss & ~ss_q`, `lr_e = btn_lr & ~lr_q`, with history flops updated every cycle. Held buttons produce exactly one edge.
- Priority within a cycle:
  - The MAX condition beats `ss_e`, which beats `lr_e`.
  - A lower-priority edge in the same cycle is discarded, not queued.
- State transitions (FSM evaluated at edge k; the resulting pulse is registered and high for exactly one cycle, k→k+1):
  - IDLE:
    - `ss_e` → RUN, emit `sw_start`.
    - `lr_e` → IDLE, emit `sw_reset`.
  - RUN:
    - `count_in >= MAX_COUNT` → MAXED, emit `sw_stop`.
    - `ss_e` → PAUSE, emit `sw_stop`.
    - `lr_e` → LAP, lap register ← `count_in`.
  - LAP:
    - MAX condition → MAXED, emit `sw_stop`.
    - `ss_e` → PAUSE, emit `sw_stop`; display returns to live.
    - `lr_e` → RUN (lap released); no pulse.
  - PAUSE:
    - `ss_e` → RUN, emit `sw_start`.
    - `lr_e` → IDLE, emit `sw_reset`.
  - MAXED:
    - `lr_e` → IDLE, emit `sw_reset`.
    - `ss_e` is ignored.
- Pulse exclusivity: at most one of `sw_start`, `sw_stop` and `sw_reset` is high in any cycle.
- `disp_count` (registered, one cycle behind its source):
  - LAP: the lap register.
  - MAXED: `MAX_COUNT`, saturated, because the counter overshoots by its stop latency.
  - Otherwise: `count_in`.
- Status outputs (`running`, `lap_active`, `maxed`): registered decodes of the next state, so they change in the same cycle as the pulse.
- Comparison: unsigned, full WIDTH.
- Counter contract: the controller does not track or predict `count_in`. It relies only on the counter honouring the pulses.
- Reset mid-operation: on `rst`, return to IDLE immediately. No `sw_reset` pulse is generated; the counter is reset by its own reset.
- Illegal state encodings recover to IDLE on the next clock.

Decomposition:
- Package `stopwatch_pkg` holds:
  - `sw_state_t` enum (IDLE, RUN, LAP, PAUSE, MAXED);
  - default `MAX_COUNT`;
  - `SW_WIDTH` = 32.
- Sub-module `rise_edge_det`: history flop with reset-to-1 and a one-cycle pulse output. Instantiated once per button.
- FSM, lap register and display mux stay in `stopwatch_ctrl`.

Test Plan:
1. Reset, then pulse `btn_ss` high for 5 cycles → single `sw_start` one cycle after the edge; `running` = 1. Holding the button adds no further pulses. Second press → single `sw_stop`; state PAUSE.
2. RUN with `count_in` ramping. Press `btn_lr` when `count_in` = 100 → `lap_active` = 1. `disp_count` holds 100 while `count_in` reaches 150. Press `btn_lr` again → `disp_count` tracks live within 1 cycle; no command pulses.
3. PAUSE, press `btn_lr` → `sw_reset` pulse; state IDLE; `disp_count` follows `count_in` = 0.
4. MAX_COUNT = 20, RUN, `count_in` reaches 20 → `sw_stop`; `maxed` = 1. `disp_count` = 20 even with `count_in` = 22. `btn_ss` is ignored. `btn_lr` → `sw_reset`, then IDLE.
5. Both buttons rise in the same cycle from IDLE → only `sw_start`; state RUN; no reset pulse. In RUN with `count_in` = 20 and `ss_e` together → one `sw_stop`; state MAXED.
6. `btn_ss` held high across `rst` deassertion → no `sw_start`. Assert `rst` mid-LAP → all outputs 0 asynchronously; state IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the two-button stopwatch controller.
package stopwatch_pkg;

    localparam int unsigned SW_WIDTH = 32;
    localparam logic [SW_WIDTH-1:0] SW_MAX_COUNT = 32'hFFFF_FF00;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StLap   = 3'd2,
        StPause = 3'd3,
        StMaxed = 3'd4
    } sw_state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a synchronized button level. History resets high so a
// button held through reset yields no edge.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic pulse_o
);

    logic hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~hist_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Button sequencer for the stopwatch counter: command pulses, lap capture,
// auto-stop at terminal count and display selection.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned       WIDTH     = SW_WIDTH,
    parameter logic [WIDTH-1:0]  MAX_COUNT = WIDTH'(SW_MAX_COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_ss,
    input  logic             btn_lr,
    input  logic [WIDTH-1:0] count_in,
    output logic             sw_start,
    output logic             sw_stop,
    output logic             sw_reset,
    output logic [WIDTH-1:0] disp_count,
    output logic             running,
    output logic             lap_active,
    output logic             maxed
);

    logic ss_e;
    logic lr_e;
    logic at_max;

    sw_state_t        state_q, state_d;
    logic [WIDTH-1:0] lap_q, lap_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic             reset_q, reset_d;

    rise_edge_det u_ss_det (
        .clk     (clk),
        .rst     (rst),
        .level_i (btn_ss),
        .pulse_o (ss_e)
    );

    rise_edge_det u_lr_det (
        .clk     (clk),
        .rst     (rst),
        .level_i (btn_lr),
        .pulse_o (lr_e)
    );

    assign at_max = (count_in >= MAX_COUNT);

    // Priority: terminal count, then start/stop, then lap/reset; losers are dropped.
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        reset_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (ss_e) begin
                    state_d = StRun;
                    start_d = 1'b1;
                end else if (lr_e) begin
                    reset_d = 1'b1;
                end
            end
            StRun: begin
                if (at_max) begin
                    state_d = StMaxed;
                    stop_d  = 1'b1;
                end else if (ss_e) begin
                    state_d = StPause;
                    stop_d  = 1'b1;
                end else if (lr_e) begin
                    state_d = StLap;
                    lap_d   = count_in;
                end
            end
            StLap: begin
                if (at_max) begin
                    state_d = StMaxed;
                    stop_d  = 1'b1;
                end else if (ss_e) begin
                    state_d = StPause;
                    stop_d  = 1'b1;
                end else if (lr_e) begin
                    state_d = StRun;
                end
            end
            StPause: begin
                if (ss_e) begin
                    state_d = StRun;
                    start_d = 1'b1;
                end else if (lr_e) begin
                    state_d = StIdle;
                    reset_d = 1'b1;
                end
            end
            StMaxed: begin
                if (lr_e) begin
                    state_d = StIdle;
                    reset_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Keyed on the next state so the display changes together with the status flags.
    always_comb begin
        case (state_d)
            StLap:   disp_d = lap_d;
            StMaxed: disp_d = MAX_COUNT;
            default: disp_d = count_in;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            lap_q   <= '0;
            disp_q  <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            reset_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lap_q   <= lap_d;
            disp_q  <= disp_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            reset_q <= reset_d;
        end
    end

    assign sw_start   = start_q;
    assign sw_stop    = stop_q;
    assign sw_reset   = reset_q;
    assign disp_count = disp_q;
    assign running    = (state_q == StRun) || (state_q == StLap);
    assign lap_active = (state_q == StLap);
    assign maxed      = (state_q == StMaxed);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a default-terminal instance and a MAX_COUNT=20 instance.
module tb_stopwatch_ctrl;

    typedef struct {
        string       name;
        logic        rst;
        logic        ss;
        logic        lr;
        logic [31:0] cnt;
        logic        sel;   // 0: default terminal count, 1: terminal count 20
        logic [2:0]  p;     // {start, stop, reset}
        logic [2:0]  st;    // {running, lap_active, maxed}
        logic [31:0] disp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_lr = 1'b0;
    logic [31:0] count_in = '0;

    logic        a_start, a_stop, a_reset, a_run, a_lap, a_max;
    logic [31:0] a_disp;
    logic        b_start, b_stop, b_reset, b_run, b_lap, b_max;
    logic [31:0] b_disp;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    stopwatch_ctrl dut_a (
        .clk        (clk),
        .rst        (rst),
        .btn_ss     (btn_ss),
        .btn_lr     (btn_lr),
        .count_in   (count_in),
        .sw_start   (a_start),
        .sw_stop    (a_stop),
        .sw_reset   (a_reset),
        .disp_count (a_disp),
        .running    (a_run),
        .lap_active (a_lap),
        .maxed      (a_max)
    );

    stopwatch_ctrl #(
        .WIDTH     (32),
        .MAX_COUNT (32'd20)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .btn_ss     (btn_ss),
        .btn_lr     (btn_lr),
        .count_in   (count_in),
        .sw_start   (b_start),
        .sw_stop    (b_stop),
        .sw_reset   (b_reset),
        .disp_count (b_disp),
        .running    (b_run),
        .lap_active (b_lap),
        .maxed      (b_max)
    );

    function automatic vec_t mk(string name, logic r, logic ss, logic lr, logic [31:0] cnt,
                                logic sel, logic [2:0] p, logic [2:0] st, logic [31:0] disp);
        vec_t v;
        v.name = name; v.rst = r; v.ss = ss; v.lr = lr; v.cnt = cnt;
        v.sel = sel; v.p = p; v.st = st; v.disp = disp;
        return v;
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_out(input vec_t v);
        logic [2:0]  p;
        logic [2:0]  st;
        logic [31:0] d;
        p  = v.sel ? {b_start, b_stop, b_reset} : {a_start, a_stop, a_reset};
        st = v.sel ? {b_run, b_lap, b_max} : {a_run, a_lap, a_max};
        d  = v.sel ? b_disp : a_disp;
        cmp({v.name, ".pulses"}, {29'd0, p}, {29'd0, v.p});
        cmp({v.name, ".status"}, {29'd0, st}, {29'd0, v.st});
        cmp({v.name, ".disp"}, d, v.disp);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; btn_ss = v.ss; btn_lr = v.lr; count_in = v.cnt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out(exp_q.pop_front());
    endtask

    initial begin
        // Default terminal count (dut_a): start/stop, pause-reset, lap, boundary auto-stop.
        vecs.push_back(mk("rst",        1, 0, 0, 0,   0, 3'b000, 3'b000, 0));
        vecs.push_back(mk("idle",       0, 0, 0, 0,   0, 3'b000, 3'b000, 0));
        vecs.push_back(mk("start",      0, 1, 0, 0,   0, 3'b100, 3'b100, 0));
        vecs.push_back(mk("hold1",      0, 1, 0, 1,   0, 3'b000, 3'b100, 1));
        vecs.push_back(mk("hold2",      0, 1, 0, 2,   0, 3'b000, 3'b100, 2));
        vecs.push_back(mk("hold3",      0, 1, 0, 3,   0, 3'b000, 3'b100, 3));
        vecs.push_back(mk("hold4",      0, 1, 0, 4,   0, 3'b000, 3'b100, 4));
        vecs.push_back(mk("rel",        0, 0, 0, 5,   0, 3'b000, 3'b100, 5));
        vecs.push_back(mk("stop",       0, 1, 0, 6,   0, 3'b010, 3'b000, 6));
        vecs.push_back(mk("paused",     0, 0, 0, 6,   0, 3'b000, 3'b000, 6));
        vecs.push_back(mk("p_reset",    0, 0, 1, 6,   0, 3'b001, 3'b000, 6));
        vecs.push_back(mk("idle0",      0, 0, 0, 0,   0, 3'b000, 3'b000, 0));
        vecs.push_back(mk("start2",     0, 1, 0, 0,   0, 3'b100, 3'b100, 0));
        vecs.push_back(mk("ramp99",     0, 0, 0, 99,  0, 3'b000, 3'b100, 99));
        vecs.push_back(mk("lap100",     0, 0, 1, 100, 0, 3'b000, 3'b110, 100));
        vecs.push_back(mk("lap_hold",   0, 0, 0, 120, 0, 3'b000, 3'b110, 100));
        vecs.push_back(mk("lap_150",    0, 0, 0, 150, 0, 3'b000, 3'b110, 100));
        vecs.push_back(mk("lap_rel",    0, 0, 1, 151, 0, 3'b000, 3'b100, 151));
        vecs.push_back(mk("live152",    0, 0, 0, 152, 0, 3'b000, 3'b100, 152));
        vecs.push_back(mk("below_max",  0, 0, 0, 32'hFFFF_FEFF, 0, 3'b000, 3'b100, 32'hFFFF_FEFF));
        vecs.push_back(mk("at_max",     0, 0, 0, 32'hFFFF_FF00, 0, 3'b010, 3'b001, 32'hFFFF_FF00));
        vecs.push_back(mk("max_ss_ign", 0, 1, 0, 32'hFFFF_FF05, 0, 3'b000, 3'b001, 32'hFFFF_FF00));
        vecs.push_back(mk("max_reset",  0, 0, 1, 7,   0, 3'b001, 3'b000, 7));
        vecs.push_back(mk("idle_again", 0, 0, 0, 0,   0, 3'b000, 3'b000, 0));
        vecs.push_back(mk("start3",     0, 1, 0, 0,   0, 3'b100, 3'b100, 0));
        vecs.push_back(mk("lap10",      0, 0, 1, 10,  0, 3'b000, 3'b110, 10));
        vecs.push_back(mk("lap_stop",   0, 1, 0, 12,  0, 3'b010, 3'b000, 12));
        vecs.push_back(mk("paused2",    0, 0, 0, 12,  0, 3'b000, 3'b000, 12));
        vecs.push_back(mk("resume",     0, 1, 0, 12,  0, 3'b100, 3'b100, 12));
        vecs.push_back(mk("run13",      0, 0, 0, 13,  0, 3'b000, 3'b100, 13));
        vecs.push_back(mk("ss_beats_lr",0, 1, 1, 14,  0, 3'b010, 3'b000, 14));
        vecs.push_back(mk("no_queue",   0, 0, 0, 14,  0, 3'b000, 3'b000, 14));
        // Terminal count 20 (dut_b): simultaneous presses, auto-stop from RUN and LAP.
        vecs.push_back(mk("b_rst",      1, 0, 0, 0,   1, 3'b000, 3'b000, 0));
        vecs.push_back(mk("b_idle",     0, 0, 0, 0,   1, 3'b000, 3'b000, 0));
        vecs.push_back(mk("b_both",     0, 1, 1, 0,   1, 3'b100, 3'b100, 0));
        vecs.push_back(mk("b_run5",     0, 0, 0, 5,   1, 3'b000, 3'b100, 5));
        vecs.push_back(mk("b_run19",    0, 0, 0, 19,  1, 3'b000, 3'b100, 19));
        vecs.push_back(mk("b_max_ss",   0, 1, 0, 20,  1, 3'b010, 3'b001, 20));
        vecs.push_back(mk("b_sat22",    0, 0, 0, 22,  1, 3'b000, 3'b001, 20));
        vecs.push_back(mk("b_ss_ign",   0, 1, 0, 23,  1, 3'b000, 3'b001, 20));
        vecs.push_back(mk("b_reset",    0, 0, 1, 24,  1, 3'b001, 3'b000, 24));
        vecs.push_back(mk("b_idle0",    0, 0, 0, 0,   1, 3'b000, 3'b000, 0));
        vecs.push_back(mk("b_start",    0, 1, 0, 0,   1, 3'b100, 3'b100, 0));
        vecs.push_back(mk("b_run19b",   0, 0, 0, 19,  1, 3'b000, 3'b100, 19));
        vecs.push_back(mk("b_max20",    0, 0, 0, 20,  1, 3'b010, 3'b001, 20));
        vecs.push_back(mk("b_sat22b",   0, 0, 0, 22,  1, 3'b000, 3'b001, 20));
        vecs.push_back(mk("b_reset2",   0, 0, 1, 0,   1, 3'b001, 3'b000, 0));
        vecs.push_back(mk("b_start2",   0, 1, 0, 0,   1, 3'b100, 3'b100, 0));
        vecs.push_back(mk("b_lap10",    0, 0, 1, 10,  1, 3'b000, 3'b110, 10));
        vecs.push_back(mk("b_lap_max",  0, 0, 0, 25,  1, 3'b010, 3'b001, 20));
        vecs.push_back(mk("b_reset3",   0, 0, 1, 0,   1, 3'b001, 3'b000, 0));
        vecs.push_back(mk("b_idle1",    0, 0, 0, 0,   1, 3'b000, 3'b000, 0));
        // Button held across reset release yields no start.
        vecs.push_back(mk("held_rst",   1, 1, 0, 0,   1, 3'b000, 3'b000, 0));
        vecs.push_back(mk("held_rel",   0, 1, 0, 0,   1, 3'b000, 3'b000, 0));
        vecs.push_back(mk("held_more",  0, 1, 0, 0,   1, 3'b000, 3'b000, 0));
        vecs.push_back(mk("held_drop",  0, 0, 0, 0,   1, 3'b000, 3'b000, 0));
        vecs.push_back(mk("c_start",    0, 1, 0, 0,   1, 3'b100, 3'b100, 0));
        vecs.push_back(mk("c_lap5",     0, 0, 1, 5,   1, 3'b000, 3'b110, 5));
        vecs.push_back(mk("c_lap_hold", 0, 0, 0, 6,   1, 3'b000, 3'b110, 5));

        foreach (vecs[i]) apply(vecs[i]);

        // Reset asserted mid-LAP must clear outputs without waiting for a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        cmp("async_rst.pulses", {29'd0, b_start, b_stop, b_reset}, 32'd0);
        cmp("async_rst.status", {29'd0, b_run, b_lap, b_max}, 32'd0);
        cmp("async_rst.disp", b_disp, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        btn_lr = 1'b0;
        @(posedge clk);
        #1;
        cmp("post_rst.status", {29'd0, b_run, b_lap, b_max}, 32'd0);
        cmp("post_rst.pulses", {29'd0, b_start, b_stop, b_reset}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
